// File: rtl/ysyx_25030093_fetch_ctrl_pkg.sv
// Shared types for the fetch controller: FSM states, reset PC, decode-queue entry.
// Optional FETCH_CTRL_PERF_EN adds performance counters in the top module.
package ysyx_25030093_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_25030093_fetch_queue.sv
// Circular-buffer FIFO toward decode with push/pop/flush; the head is read from storage,
// so a pushed entry becomes visible one cycle later.
module ysyx_25030093_fetch_queue
  import ysyx_25030093_fetch_ctrl_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_s;
  logic          full_s;

  assign empty  = (count_r == {CW{1'b0}});
  assign full_s = (count_r == CW'(DEPTH));
  assign pop_s  = pop && !empty;
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];

  // pointer and occupancy update; flush empties the queue and wins over push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // entry storage write
  always_ff @(posedge clk) begin
    if (push && !flush) mem_r[wr_ptr_r] <= wdata;
  end

  ysyx_25030093_fetch_queue_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop_s),
    .full (full_s)
  );

endmodule

// File: rtl/ysyx_25030093_fetch_queue_chk.sv
// Protocol checker for the decode queue: a push into a full queue without a pop is illegal.
module ysyx_25030093_fetch_queue_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);

  // flag overflow attempts on every clock edge outside reset
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/ysyx_25030093_fetch_ctrl.sv
// IFU requester: owns the fetch PC, handles redirects/flushes, queues (pc, inst) toward decode.
// Define FETCH_CTRL_PERF_EN to add fetch/stall/flush performance counters.
module ysyx_25030093_fetch_ctrl
  import ysyx_25030093_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic        ready,
  input  logic        valid,
  input  logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e  state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic [31:0]   tgt_r, tgt_s;
  logic          push_s, discard_s, pop_s, xfer_s;
  logic          room_idle_s, room_after_push_s;
  logic [CW-1:0] q_count_s;
  logic          q_empty_s;
  fetch_entry_t  head_s;
  fetch_entry_t  wdata_s;

  assign ready     = (state_r != IDLE);
  assign pc        = pc_r;
  assign out_valid = !q_empty_s;
  assign out_inst  = head_s.inst;
  assign out_pc    = head_s.pc;
  assign xfer_s    = valid && ready;
  assign pop_s     = out_valid && out_ready;
  assign wdata_s   = '{pc: pc_r, inst: inst};

  assign room_idle_s       = (q_count_s < CW'(QDEPTH)) || pop_s;
  assign room_after_push_s = ((q_count_s + CW'(1)) < CW'(QDEPTH)) || pop_s;

  // next-state, next-pc and queue-push decisions
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    tgt_s     = tgt_r;
    push_s    = 1'b0;
    discard_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (redirect_valid) begin
          pc_s    = redirect_pc;
          state_s = REQ;
        end else if (room_idle_s) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (xfer_s && redirect_valid) begin
          discard_s = 1'b1;
          pc_s      = redirect_pc;
        end else if (xfer_s) begin
          push_s  = 1'b1;
          pc_s    = pc_r + 32'd4;
          state_s = room_after_push_s ? REQ : IDLE;
        end else if (redirect_valid) begin
          tgt_s   = redirect_pc;
          state_s = FLUSH;
        end else begin
          state_s = REQ;
        end
      end
      FLUSH: begin
        // the response in flight belongs to the abandoned stream; newest target wins
        if (xfer_s) begin
          discard_s = 1'b1;
          pc_s      = redirect_valid ? redirect_pc : tgt_r;
          state_s   = REQ;
        end else if (redirect_valid) begin
          tgt_s = redirect_pc;
        end else begin
          tgt_s = tgt_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // architectural fetch state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      tgt_r   <= RESET_PC;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      tgt_r   <= tgt_s;
    end
  end

  ysyx_25030093_fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .wdata (wdata_s),
    .head  (head_s),
    .count (q_count_s),
    .empty (q_empty_s)
  );

`ifdef FETCH_CTRL_PERF_EN
  logic [63:0] fetch_cnt_r, stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // free-running event counters, wrapping on overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_r <= 64'd0;
      stall_cnt_r <= 64'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (push_s) fetch_cnt_r <= fetch_cnt_r + 64'd1;
      if (state_r == REQ && !valid) stall_cnt_r <= stall_cnt_r + 64'd1;
      if (discard_s) flush_cnt_r <= flush_cnt_r + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_r;
  assign perf_stall_cnt = stall_cnt_r;
  assign perf_flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_ysyx_25030093_fetch_ctrl.sv
// Directed self-checking bench for ysyx_25030093_fetch_ctrl (QDEPTH=2).
module tb_ysyx_25030093_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic        ready;
  logic        valid;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I0 = 32'h0000_0113;
  localparam logic [31:0] I1 = 32'h0040_0193;
  localparam logic [31:0] I2 = 32'h0080_0213;
  localparam logic [31:0] I3 = 32'h00C0_0293;
  localparam logic [31:0] I4 = 32'h0100_0313;
  localparam logic [31:0] I5 = 32'h0140_0393;
  localparam logic [31:0] I6 = 32'h0180_0413;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  ysyx_25030093_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .ready          (ready),
    .valid          (valid),
    .inst           (inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef FETCH_CTRL_PERF_EN
  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    valid = 1'b0; inst = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk32("rst_pc", pc, 32'h8000_0000);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    step();
    rst = 1'b0;

    // IDLE -> REQ, then back-to-back fetches with decode always ready
    step();
    chk1("req_ready", ready, 1'b1);
    chk32("req_pc0", pc, 32'h8000_0000);
    chk1("req_out_valid0", out_valid, 1'b0);
    valid = 1'b1; inst = I0; out_ready = 1'b1;
    step();
    chk32("seq_pc1", pc, 32'h8000_0004);
    chk1("seq_out_valid1", out_valid, 1'b1);
    chk32("seq_out_pc1", out_pc, 32'h8000_0000);
    chk32("seq_out_inst1", out_inst, I0);
    inst = I1;
    step();
    chk32("seq_pc2", pc, 32'h8000_0008);
    chk32("seq_out_pc2", out_pc, 32'h8000_0004);
    chk32("seq_out_inst2", out_inst, I1);

    // decode stalls: queue fills to two entries, fetching stops
    inst = I2; out_ready = 1'b0;
    step();
    chk1("full_ready", ready, 1'b0);
    chk32("full_pc", pc, 32'h8000_000C);
    valid = 1'b0;
    repeat (4) step();
    chk1("hold_ready", ready, 1'b0);
    chk32("hold_pc", pc, 32'h8000_000C);
    chk1("hold_out_valid", out_valid, 1'b1);
    chk32("hold_out_pc", out_pc, 32'h8000_0004);
    chk32("hold_out_inst", out_inst, I1);
    out_ready = 1'b1;
    step();
    chk1("drain_ready", ready, 1'b1);
    chk32("drain_out_pc", out_pc, 32'h8000_0008);
    chk32("drain_out_inst", out_inst, I2);
    step();
    chk1("drain_empty", out_valid, 1'b0);
    chk32("drain_pc", pc, 32'h8000_000C);

    // redirect while a request is open with no response -> FLUSH
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    chk1("flush_ready", ready, 1'b1);
    chk32("flush_pc_held", pc, 32'h8000_000C);
    redirect_valid = 1'b0;
    repeat (2) step();
    chk32("flush_pc_wait", pc, 32'h8000_000C);
    chk1("flush_out_valid_wait", out_valid, 1'b0);
    valid = 1'b1; inst = STALE;
    step();
    chk32("flush_new_pc", pc, 32'h8000_0100);
    chk1("flush_stale_dropped", out_valid, 1'b0);
    chk1("flush_back_req", ready, 1'b1);

    // redirect coincident with a transfer
    out_ready = 1'b0; inst = I3;
    step();
    chk32("co_push_out_pc", out_pc, 32'h8000_0100);
    chk32("co_push_out_inst", out_inst, I3);
    chk32("co_push_pc", pc, 32'h8000_0104);
    inst = I4; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    chk32("co_pc", pc, 32'h8000_0200);
    chk1("co_queue_flushed", out_valid, 1'b0);
    chk1("co_ready", ready, 1'b1);
    redirect_valid = 1'b0; inst = I5;
    step();
    chk1("co_next_valid", out_valid, 1'b1);
    chk32("co_next_out_pc", out_pc, 32'h8000_0200);
    chk32("co_next_out_inst", out_inst, I5);
    chk32("co_next_pc", pc, 32'h8000_0204);

    // PC wrap at the top of the address space
    valid = 1'b0; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk1("wrap_flush_q", out_valid, 1'b0);
    chk32("wrap_pc_held", pc, 32'h8000_0204);
    redirect_valid = 1'b0; valid = 1'b1; inst = STALE;
    step();
    chk32("wrap_pc_target", pc, 32'hFFFF_FFFC);
    inst = I6;
    step();
    chk32("wrap_pc_zero", pc, 32'h0000_0000);
    chk32("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    chk32("wrap_out_inst", out_inst, I6);

    // enter FLUSH, then assert reset between clock edges
    valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    redirect_valid = 1'b0;
    chk1("pre_rst_ready", ready, 1'b1);
    chk32("pre_rst_pc", pc, 32'h0000_0000);
    chk1("pre_rst_out_valid", out_valid, 1'b0);
`ifdef FETCH_CTRL_PERF_EN
    chk64("perf_fetch", perf_fetch_cnt, 64'd6);
    chk64("perf_stall", perf_stall_cnt, 64'd4);
    chk32("perf_flush", perf_flush_cnt, 32'd3);
`endif
    #3 rst = 1'b1;
    #1;
    chk1("arst_ready", ready, 1'b0);
    chk1("arst_out_valid", out_valid, 1'b0);
    chk32("arst_pc", pc, 32'h8000_0000);
`ifdef FETCH_CTRL_PERF_EN
    chk64("arst_perf_fetch", perf_fetch_cnt, 64'd0);
    chk64("arst_perf_stall", perf_stall_cnt, 64'd0);
    chk32("arst_perf_flush", perf_flush_cnt, 32'd0);
`endif
    step();
    rst = 1'b0;
    step();
    chk1("post_rst_ready", ready, 1'b1);
    chk32("post_rst_pc", pc, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
